// File: rtl/alu_pkg.sv
// Shared opcode and FSM definitions for alu and alu_arbiter.
package alu_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [2:0] {
        OP_ZERO = 3'b000,
        OP_ADD  = 3'b001,
        OP_SUB  = 3'b010,
        OP_AND  = 3'b011,
        OP_OR   = 3'b100,
        OP_XOR  = 3'b101,
        OP_SRL1 = 3'b110,
        OP_SLL1 = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // Only add and sub produce a meaningful signed overflow flag.
    function automatic logic is_arith(input op_t op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU; overflow is only meaningful for add/sub and is left to
// the caller to mask for other opcodes.
module alu
    import alu_pkg::*;
#(
    parameter int bit_width = 4
) (
    input  op_t                  op,
    input  logic [bit_width-1:0] x,
    input  logic [bit_width-1:0] y,
    output logic [bit_width-1:0] result,
    output logic                 overflow
);

    logic [bit_width-1:0] sum;
    logic [bit_width-1:0] diff;
    logic                 add_ovf;
    logic                 sub_ovf;

    assign sum  = x + y;
    assign diff = x - y;

    assign add_ovf = (x[bit_width-1] == y[bit_width-1]) && (sum[bit_width-1] != x[bit_width-1]);
    assign sub_ovf = (x[bit_width-1] != y[bit_width-1]) && (diff[bit_width-1] != x[bit_width-1]);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        result   = '0;
        overflow = (op == OP_SUB) ? sub_ovf : add_ovf;
        case (op)
            OP_ZERO: result = '0;
            OP_ADD:  result = sum;
            OP_SUB:  result = diff;
            OP_AND:  result = x & y;
            OP_OR:   result = x | y;
            OP_XOR:  result = x ^ y;
            OP_SRL1: result = x >> 1;
            OP_SLL1: result = x << 1;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared ALU, one operation
// in flight. Optional sticky overflow flag enabled by ALU_ARB_STICKY_OVF_EN.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int BIT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
`ifdef ALU_ARB_STICKY_OVF_EN
    input  logic                 ovf_clear,
    output logic                 ovf_sticky,
`else
`endif
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [2:0]           req_op0,
    input  logic [2:0]           req_op1,
    input  logic [BIT_WIDTH-1:0] req_x0,
    input  logic [BIT_WIDTH-1:0] req_y0,
    input  logic [BIT_WIDTH-1:0] req_x1,
    input  logic [BIT_WIDTH-1:0] req_y1,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [BIT_WIDTH-1:0] rsp_result,
    output logic                 rsp_overflow
);

    state_t               state;
    state_t               state_next;
    logic                 last_grant;
    logic                 grant_any;
    logic                 grant_id;
    logic                 grant_fire;
    logic                 rsp_fire;

    op_t                  op_q;
    logic [BIT_WIDTH-1:0] x_q;
    logic [BIT_WIDTH-1:0] y_q;
    logic                 id_q;

    logic [BIT_WIDTH-1:0] alu_result;
    logic                 alu_overflow;

    // Under contention the requester not served last wins; a lone requester always wins.
    assign grant_any  = |req_valid;
    assign grant_id   = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
    assign grant_fire = (state == ST_IDLE) && grant_any;
    assign rsp_fire   = rsp_valid && rsp_ready;

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (grant_any) state_next = ST_EXEC;
            ST_EXEC: state_next = ST_RESP;
            ST_RESP: if (rsp_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready = '0;
        rsp_valid = 1'b0;
        case (state)
            ST_IDLE: if (grant_any && !reset) req_ready = grant_id ? 2'b10 : 2'b01;
            ST_RESP: rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Operand capture at grant, result capture at the end of EXEC.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant   <= 1'b1;
            op_q         <= OP_ZERO;
            x_q          <= '0;
            y_q          <= '0;
            id_q         <= 1'b0;
            rsp_result   <= '0;
            rsp_overflow <= 1'b0;
        end else begin
            if (grant_fire) begin
                last_grant <= grant_id;
                id_q       <= grant_id;
                op_q       <= grant_id ? op_t'(req_op1) : op_t'(req_op0);
                x_q        <= grant_id ? req_x1 : req_x0;
                y_q        <= grant_id ? req_y1 : req_y0;
            end
            if (state == ST_EXEC) begin
                rsp_result   <= alu_result;
                rsp_overflow <= is_arith(op_q) && alu_overflow;
            end
        end
    end

    assign rsp_id = id_q;

    alu #(
        .bit_width(BIT_WIDTH)
    ) u_alu (
        .op      (op_q),
        .x       (x_q),
        .y       (y_q),
        .result  (alu_result),
        .overflow(alu_overflow)
    );

`ifdef ALU_ARB_STICKY_OVF_EN
    // A handshake with overflow beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_sticky <= 1'b0;
        end else if (rsp_fire && rsp_overflow) begin
            ovf_sticky <= 1'b1;
        end else if (ovf_clear) begin
            ovf_sticky <= 1'b0;
        end
    end
`else
    logic unused_rsp_fire;
    assign unused_rsp_fire = rsp_fire;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed cases plus randomized traffic
// against an arithmetic reference model. Build with ALU_ARB_STICKY_OVF_EN to cover the sticky flag.
module tb_alu_arbiter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [2:0]   req_op0, req_op1;
    logic [W-1:0] req_x0, req_y0, req_x1, req_y1;
    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [W-1:0] rsp_result;
    logic         rsp_overflow;
`ifdef ALU_ARB_STICKY_OVF_EN
    logic         ovf_clear;
    logic         ovf_sticky;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int exp_last    = 1;
    int grants[2]   = '{0, 0};

    always #5 clk = ~clk;

    alu_arbiter #(.BIT_WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
`ifdef ALU_ARB_STICKY_OVF_EN
        .ovf_clear   (ovf_clear),
        .ovf_sticky  (ovf_sticky),
`endif
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op0     (req_op0),
        .req_op1     (req_op1),
        .req_x0      (req_x0),
        .req_y0      (req_y0),
        .req_x1      (req_x1),
        .req_y1      (req_y1),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_result  (rsp_result),
        .rsp_overflow(rsp_overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: signed operands as plain integers, result reduced modulo 2**W.
    task automatic ref_alu(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                           output logic [W-1:0] r, output logic o);
        int ux, uy, sx, sy, full;
        ux = int'(x);
        uy = int'(y);
        sx = (ux >= 2 ** (W - 1)) ? ux - 2 ** W : ux;
        sy = (uy >= 2 ** (W - 1)) ? uy - 2 ** W : uy;
        o  = 1'b0;
        case (op)
            3'd1:    full = sx + sy;
            3'd2:    full = sx - sy;
            3'd3:    full = ux & uy;
            3'd4:    full = ux | uy;
            3'd5:    full = ux ^ uy;
            3'd6:    full = ux / 2;
            3'd7:    full = ux * 2;
            default: full = 0;
        endcase
        if (op == 3'd1 || op == 3'd2)
            o = (full > 2 ** (W - 1) - 1) || (full < -(2 ** (W - 1)));
        r = full[W-1:0];
    endtask

    task automatic randomize_req(input int i);
        if (i == 0) begin
            req_op0 = 3'($urandom); req_x0 = W'($urandom); req_y0 = W'($urandom);
        end else begin
            req_op1 = 3'($urandom); req_x1 = W'($urandom); req_y1 = W'($urandom);
        end
    endtask

    // One full operation; starts and ends just after a falling edge with the DUT idle.
    task automatic txn(input logic [1:0] valid, input int delay);
        int           g;
        logic [W-1:0] er;
        logic         eo;
        logic [W-1:0] held;
        req_valid = valid;
        #1;
        g = (valid == 2'b11) ? 1 - exp_last : (valid[1] ? 1 : 0);
        check("grant", req_ready, (g == 1) ? 2'b10 : 2'b01);
        if (g == 0) ref_alu(req_op0, req_x0, req_y0, er, eo);
        else        ref_alu(req_op1, req_x1, req_y1, er, eo);
        exp_last = g;
        grants[g]++;
        @(negedge clk);
        req_valid[g] = 1'b0;
        randomize_req(g);
        check("exec_rsp_valid", rsp_valid, 1'b0);
        check("exec_req_ready", req_ready, 2'b00);
        @(negedge clk);
        check("rsp_valid", rsp_valid, 1'b1);
        check("rsp_id", rsp_id, g);
        check("rsp_result", rsp_result, er);
        check("rsp_overflow", rsp_overflow, eo);
        held = rsp_result;
        for (int d = 0; d < delay; d++) begin
            @(negedge clk);
            check("hold_rsp_valid", rsp_valid, 1'b1);
            check("hold_rsp_result", rsp_result, er);
            check("hold_rsp_id", rsp_id, g);
            check("hold_req_ready", req_ready, 2'b00);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("post_rsp_valid", rsp_valid, 1'b0);
    endtask

    initial begin
        reset = 1'b1; req_valid = 2'b00; rsp_ready = 1'b0;
        req_op0 = 3'd0; req_op1 = 3'd0;
        req_x0 = '0; req_y0 = '0; req_x1 = '0; req_y1 = '0;
`ifdef ALU_ARB_STICKY_OVF_EN
        ovf_clear = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_req_ready", req_ready, 2'b00);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_id", rsp_id, 1'b0);
        check("rst_rsp_result", rsp_result, '0);
        check("rst_rsp_overflow", rsp_overflow, 1'b0);
        req_valid = 2'b11;
        #1;
        check("rst_req_ready_valid", req_ready, 2'b00);
        req_valid = 2'b00;
        reset = 1'b0;
        @(negedge clk);

        // Requester 0: 7 + 1 overflows to 8
        req_op0 = 3'd1; req_x0 = 4'd7; req_y0 = 4'd1;
        txn(2'b01, 0);
`ifdef ALU_ARB_STICKY_OVF_EN
        check("sticky_set", ovf_sticky, 1'b1);
        ovf_clear = 1'b1;
        @(negedge clk);
        ovf_clear = 1'b0;
        check("sticky_clear", ovf_sticky, 1'b0);
`endif

        // Requester 1: 0 - 1 wraps to 15 without signed overflow
        req_op1 = 3'd2; req_x1 = 4'd0; req_y1 = 4'd1;
        txn(2'b10, 0);

        // Overflowing add followed by xor: stale ALU overflow must be masked
        req_op0 = 3'd1; req_x0 = 4'd7; req_y0 = 4'd1;
`ifdef ALU_ARB_STICKY_OVF_EN
        ovf_clear = 1'b1;
`endif
        txn(2'b01, 0);
`ifdef ALU_ARB_STICKY_OVF_EN
        ovf_clear = 1'b0;
        check("sticky_set_wins", ovf_sticky, 1'b1);
`endif
        req_op0 = 3'd5; req_x0 = 4'hA; req_y0 = 4'h5;
        txn(2'b01, 0);
        check("xor_result_direct", rsp_result, 4'hF);
        check("xor_overflow_direct", rsp_overflow, 1'b0);

        // Continuous contention: grants must alternate
        grants = '{0, 0};
        for (int i = 0; i < 8; i++) begin
            randomize_req(0);
            randomize_req(1);
            txn(2'b11, 0);
        end
        check("fair_req0", grants[0], 4);
        check("fair_req1", grants[1], 4);

        // Back-pressure: response held for 5 cycles
        randomize_req(1);
        txn(2'b10, 5);

        // Reset during EXEC aborts the operation and restores requester 0 priority
        req_op0 = 3'd1; req_x0 = 4'd3; req_y0 = 4'd4;
        req_valid = 2'b01;
        #1;
        check("abort_grant", req_ready, 2'b01);
        @(negedge clk);
        req_valid = 2'b00;
        reset = 1'b1;
        @(negedge clk);
        check("abort_rsp_valid", rsp_valid, 1'b0);
        check("abort_rsp_result", rsp_result, '0);
        check("abort_rsp_id", rsp_id, 1'b0);
        reset = 1'b0;
        exp_last = 1;
        repeat (2) begin
            @(negedge clk);
            check("abort_no_rsp", rsp_valid, 1'b0);
        end
        randomize_req(0);
        randomize_req(1);
        txn(2'b11, 0);

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            randomize_req(0);
            randomize_req(1);
            txn(2'($urandom_range(1, 3)), int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 4: operand/result width, passed to the ALU instance.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port req_valid  input  2  per-requester request valid (bit i = requester i).
REQ-005 SHALL have port req_ready  output  2  per-requester accept strobe, one-hot or zero.
REQ-006 SHALL have port req_op0, req_op1  input  3 each  opcode (001 add, 010 sub, 011 and, 100 or, 101 xor, 110 srl1, 111 sll1, 000 zero).
REQ-007 SHALL have port req_x0, req_y0, req_x1, req_y1  input  BIT_WIDTH each  operands.
REQ-008 SHALL have port rsp_valid  output  1  response valid.
REQ-009 SHALL have port rsp_ready  input  1  response consumer ready.
REQ-010 SHALL have port rsp_id  output  1  index of the requester owning the response.
REQ-011 SHALL have port rsp_result  output  BIT_WIDTH  ALU result.
REQ-012 SHALL have port rsp_overflow  output  1  signed overflow, masked per REQ-020.
REQ-013 SHALL have ports ovf_sticky  output  1  and ovf_clear  input  1, present only per REQ-026.

Function
REQ-014 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE; one operation in flight.
REQ-015 IDLE: if any req_valid bit set, SHALL assert req_ready for exactly one granted bit that cycle, latch its op/x/y/id, go to EXEC; else stay IDLE, req_ready=0.
REQ-016 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; single valid always granted.
REQ-017 Round-robin pointer SHALL update only on an actual grant.
REQ-018 EXEC: SHALL drive latched operands into the ALU and register its result/overflow at the end of the cycle; go to RESP.
REQ-019 RESP: rsp_valid=1 with stable rsp_id/rsp_result/rsp_overflow; on rsp_valid&&rsp_ready SHALL return to IDLE next cycle; otherwise hold indefinitely.
REQ-020 rsp_overflow SHALL equal ALU overflow for ops 001/010 and be 0 for all other ops (ALU overflow is stale for non-arithmetic ops).
REQ-021 Latency: grant cycle to rsp_valid = 2 cycles; minimum 3 cycles per operation; no new grant while EXEC or RESP.
REQ-022 req_valid changes outside IDLE SHALL be ignored; requesters hold req_valid until their req_ready.

Reset
REQ-023 On reset: state IDLE, req_ready=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_overflow=0, pointer so requester 0 wins the first contention.
REQ-024 Reset in any state, including mid-EXEC or mid-RESP, SHALL abort and discard the operation; no response produced.
REQ-025 Reset SHALL take priority over every other event in the same cycle.

Configuration
REQ-026 Macro ALU_ARB_STICKY_OVF_EN defined: ovf_sticky SHALL set on the cycle after any response handshake with rsp_overflow=1, clear on ovf_clear (set wins if simultaneous), reset to 0; undefined: ports ovf_sticky/ovf_clear and the register absent.

Structure
REQ-027 Opcode constants (OP_ZERO..OP_SLL1) and FSM state enum SHALL live in shared package alu_pkg.
REQ-028 SHALL instantiate exactly one sub-module, the team's existing alu, with bit_width=BIT_WIDTH; no duplicate ALU logic.

Verification
REQ-029 Req0 add x=7,y=1 -> grant cycle N, rsp_valid at N+2, rsp_result=8, rsp_overflow=1, rsp_id=0.
REQ-030 Req1 sub x=0,y=1 -> rsp_result=15, rsp_overflow=0, rsp_id=1; then xor 0xA,0x5 after an overflowing add -> result 0xF, overflow 0.
REQ-031 Both valid continuously, 4 ops each -> grants alternate 0,1,0,1...; no requester starved.
REQ-032 rsp_ready held low 5 cycles in RESP -> outputs stable, req_ready stays 0, completes on first rsp_ready.
REQ-033 Reset asserted in EXEC -> next cycle IDLE, rsp_valid never asserts for aborted op, next contention grants requester 0.
REQ-034 With ALU_ARB_STICKY_OVF_EN: overflowing add then ovf_clear -> ovf_sticky 1 then 0; simultaneous set/clear -> 1.
